// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between two ALU requesters and alu_req_arbiter.
// slave: the arbiter side. master: the requester/consumer side.
interface alu_req_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_src1;
  logic [31:0] req0_src2;
  logic [4:0]  req0_shamt;
  logic [5:0]  req0_funct;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_src1;
  logic [31:0] req1_src2;
  logic [4:0]  req1_shamt;
  logic [5:0]  req1_funct;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_src1, req0_src2, req0_shamt, req0_funct,
    input  req1_valid, req1_src1, req1_src2, req1_shamt, req1_funct,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_src1, req0_src2, req0_shamt, req0_funct,
    output req1_valid, req1_src1, req1_src2, req1_shamt, req1_funct,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-port arbiter sharing one 32-bit ALU; one op in flight, IDLE -> EXEC -> RESP.
// Define ALU_ARB_PRIO_EN for fixed port-0 priority with a port-1 starvation guard.
module alu_req_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_req_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [5:0] FN_ADD = 6'b001001;
  localparam logic [5:0] FN_SUB = 6'b001010;
  localparam logic [5:0] FN_AND = 6'b010001;
  localparam logic [5:0] FN_SLL = 6'b100001;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  // Returns {err, carry, result}; bit 32 of the 33-bit shift is src1[32-shamt].
  function automatic logic [33:0] alu_eval(
    input logic [5:0]  funct,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  sh
  );
    logic [32:0] wide;
    logic        err;
    wide = 33'd0;
    err  = 1'b0;
    case (funct)
      FN_ADD:  wide = {1'b0, a} + {1'b0, b};
      FN_SUB:  wide = {1'b0, a} - {1'b0, b};
      FN_AND:  wide = {1'b0, a & b};
      FN_SLL:  wide = {1'b0, a} << sh;
      default: begin
        wide = 33'd0;
        err  = 1'b1;
      end
    endcase
    return {err, wide};
  endfunction

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] src1_q, src2_q;
  logic [4:0]  shamt_q;
  logic [5:0]  funct_q;
  logic        id_q;
  logic        rsp_id_q, rsp_zero_q, rsp_carry_q, rsp_err_q;
  logic [31:0] rsp_result_q;
  logic        grant_any, grant_id, accept;
  logic [33:0] alu_out;

`ifdef ALU_ARB_PRIO_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_q, starve_d;
`endif

  // Arbitration winner among the valid ports
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_PRIO_EN
      grant_id = (starve_q >= LIMIT) ? 1'b1 : 1'b0;
`else
      grant_id = ~last_q;
`endif
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
  end

  // Ready is gated by rst_n so every output is low while reset is held.
  assign accept         = (state_q == ST_IDLE) & grant_any;
  assign bus.req0_ready = rst_n & accept & ~grant_id;
  assign bus.req1_ready = rst_n & accept & grant_id;

  // Next-state and round-robin pointer
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d = ST_EXEC;
          last_d  = grant_id;
        end else begin
          state_d = ST_IDLE;
          last_d  = last_q;
        end
        rsp_valid_d = 1'b0;
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Operand capture from the winning port on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      shamt_q <= 5'd0;
      funct_q <= 6'd0;
      id_q    <= 1'b0;
    end else if (accept) begin
      src1_q  <= grant_id ? bus.req1_src1  : bus.req0_src1;
      src2_q  <= grant_id ? bus.req1_src2  : bus.req0_src2;
      shamt_q <= grant_id ? bus.req1_shamt : bus.req0_shamt;
      funct_q <= grant_id ? bus.req1_funct : bus.req0_funct;
      id_q    <= grant_id;
    end
  end

  assign alu_out = alu_eval(funct_q, src1_q, src2_q, shamt_q);

  // Response registers load in EXEC and hold through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_id_q     <= id_q;
      rsp_result_q <= alu_out[31:0];
      rsp_zero_q   <= (alu_out[31:0] == 32'd0);
      rsp_carry_q  <= alu_out[32];
      rsp_err_q    <= alu_out[33];
    end
  end

`ifdef ALU_ARB_PRIO_EN
  // Count port-0 wins while port 1 waits; saturates at the limit
  always_comb begin
    starve_d = starve_q;
    if (!bus.req1_valid) begin
      starve_d = '0;
    end else if (accept && grant_id) begin
      starve_d = '0;
    end else if (accept && !grant_id && (starve_q < LIMIT)) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: transaction-level reference model
// compared every cycle, plus directed ops with hand-computed expectations.
module tb_alu_req_arbiter;

  localparam logic [5:0] F_ADD = 6'b001001;
  localparam logic [5:0] F_SUB = 6'b001010;
  localparam logic [5:0] F_AND = 6'b010001;
  localparam logic [5:0] F_SLL = 6'b100001;
  localparam logic [5:0] F_BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_req_arbiter_if bus ();

  alu_req_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: {err, zero, carry, result} from plain 64-bit arithmetic
  function automatic logic [34:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    logic [63:0] x;
    logic [31:0] r;
    logic        c;
    logic        e;
    x = 64'd0; r = 32'd0; c = 1'b0; e = 1'b0;
    case (f)
      F_ADD: begin x = {32'd0, a} + {32'd0, b}; r = x[31:0]; c = x[32]; end
      F_SUB: begin r = a - b; c = (a < b); end
      F_AND: begin r = a & b; c = 1'b0; end
      F_SLL: begin x = {32'd0, a} << sh; r = x[31:0]; c = x[32]; end
      default: begin r = 32'd0; c = 1'b0; e = 1'b1; end
    endcase
    return {e, (r == 32'd0), c, r};
  endfunction

  // Winner by the arbitration rules: -1 none, else port number
  function automatic int pick(input logic v0, input logic v1, input int last, input int starve);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef ALU_ARB_PRIO_EN
    return (starve >= 4) ? 1 : 0;
`else
    return 1 - last;
`endif
  endfunction

  // Model: phase 0 idle, 1 computing, 2 holding a response
  int          m_phase;
  int          m_last;
  int          m_starve;
  int          m_id;
  bit          m_valid;
  logic [34:0] m_rsp;
  int          m_win;

  assign m_win = (m_phase == 0) ? pick(bus.req0_valid, bus.req1_valid, m_last, m_starve) : -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_last <= 1; m_starve <= 0; m_valid <= 1'b0; m_id <= 0; m_rsp <= '0;
    end else begin
      if (m_phase == 0 && m_win >= 0) begin
        m_phase <= 1;
        m_last  <= m_win;
        m_id    <= m_win;
        m_rsp   <= (m_win == 0) ? ref_op(bus.req0_funct, bus.req0_src1, bus.req0_src2, bus.req0_shamt)
                                : ref_op(bus.req1_funct, bus.req1_src1, bus.req1_src2, bus.req1_shamt);
      end else if (m_phase == 1) begin
        m_phase <= 2;
        m_valid <= 1'b1;
      end else if (m_phase == 2 && bus.rsp_ready) begin
        m_phase <= 0;
        m_valid <= 1'b0;
      end
      if (!bus.req1_valid || m_win == 1) m_starve <= 0;
      else if (m_win == 0) m_starve <= m_starve + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_ready0", {31'd0, bus.req0_ready}, {31'd0, (m_win == 0)});
      check("m_ready1", {31'd0, bus.req1_ready}, {31'd0, (m_win == 1)});
      check("m_rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check("m_rsp_id", {31'd0, bus.rsp_id}, 32'(m_id));
        check("m_rsp_result", bus.rsp_result, m_rsp[31:0]);
        check("m_rsp_carry", {31'd0, bus.rsp_carry}, {31'd0, m_rsp[32]});
        check("m_rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, m_rsp[33]});
        check("m_rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_rsp[34]});
      end
    end
  end

  task automatic set_op(input int p, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    if (p == 0) begin
      bus.req0_funct = f; bus.req0_src1 = a; bus.req0_src2 = b; bus.req0_shamt = sh;
    end else begin
      bus.req1_funct = f; bus.req1_src1 = a; bus.req1_src2 = b; bus.req1_shamt = sh;
    end
  endtask

  // Issue one op, check grant, latency and the literal response; ends at the negedge showing rsp_valid
  task automatic run_op(input string name, input int p, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [34:0] exp);
    logic got;
    set_op(p, f, a, b, sh);
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 1'b1; else bus.req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check({name, "_grant"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    check({name, "_exec_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({name, "_id"}, {31'd0, bus.rsp_id}, 32'(p));
    check({name, "_result"}, bus.rsp_result, exp[31:0]);
    check({name, "_carry"}, {31'd0, bus.rsp_carry}, {31'd0, exp[32]});
    check({name, "_zero"}, {31'd0, bus.rsp_zero}, {31'd0, exp[33]});
    check({name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp[34]});
  endtask

  int exp_order[6];
  int g;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ALU_ARB_PRIO_EN
    exp_order = '{0, 0, 0, 0, 1, 0};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    set_op(0, F_ADD, 32'd0, 32'd0, 5'd0);
    set_op(1, F_ADD, 32'd0, 32'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
    check("rst_rsp_carry", {31'd0, bus.rsp_carry}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    run_op("add_wrap", 0, F_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, {1'b0, 1'b1, 1'b1, 32'h0000_0000});
    run_op("sub_borrow", 1, F_SUB, 32'h0000_0005, 32'h0000_0007, 5'd0, {1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE});
    run_op("sll_1", 1, F_SLL, 32'h8000_0001, 32'd0, 5'd1, {1'b0, 1'b0, 1'b1, 32'h0000_0002});
    run_op("and", 0, F_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, {1'b0, 1'b0, 1'b0, 32'h00F0_1200});
    run_op("sll_0", 0, F_SLL, 32'h0000_0001, 32'd0, 5'd0, {1'b0, 1'b0, 1'b0, 32'h0000_0001});
    run_op("sll_31", 0, F_SLL, 32'h0000_0003, 32'd0, 5'd31, {1'b0, 1'b0, 1'b1, 32'h8000_0000});
    run_op("add_ovf", 1, F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, {1'b0, 1'b0, 1'b0, 32'h8000_0000});
    run_op("illegal", 1, F_BAD, 32'h0000_1234, 32'h0000_0055, 5'd3, {1'b1, 1'b1, 1'b0, 32'h0000_0000});

    // Contention: both ports held valid across six grants
    set_op(0, F_ADD, 32'd10, 32'd20, 5'd0);
    set_op(1, F_SUB, 32'd100, 32'd1, 5'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = -1;
      for (int i = 0; i < 20 && g < 0; i++) begin
        @(negedge clk);
        if (bus.req0_ready) g = 0;
        else if (bus.req1_ready) g = 1;
      end
      check($sformatf("arb_order_%0d", k), 32'(g), 32'(exp_order[k]));
      @(posedge clk); #1;
      if (k == 5) begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    #1;

    // Backpressure with a pending port-0 request
    bus.rsp_ready = 1'b0;
    run_op("sub_eq", 0, F_SUB, 32'd3, 32'd3, 5'd0, {1'b0, 1'b1, 1'b0, 32'h0000_0000});
    set_op(0, F_ADD, 32'd2, 32'd3, 5'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp_result", bus.rsp_result, 32'd0);
      check("bp_zero", {31'd0, bus.rsp_zero}, 32'd1);
      check("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    check("bp_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("bp_idle_ready0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_result", bus.rsp_result, 32'd5);
    @(posedge clk); #1;

    // Reset while holding a response
    bus.rsp_ready = 1'b0;
    run_op("pre_rst", 0, F_ADD, 32'd1, 32'd1, 5'd0, {1'b0, 1'b0, 1'b0, 32'h0000_0002});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("async_rst_result", bus.rsp_result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    bus.rsp_ready = 1'b1;

    // First contention after reset goes to port 0
    set_op(0, F_AND, 32'hFFFF_0000, 32'h00FF_FF00, 5'd0);
    set_op(1, F_ADD, 32'd1, 32'd2, 5'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    check("rst_contend_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("rst_contend_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_contend_result", bus.rsp_result, 32'h00FF_0000);
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
